mul_add_seq: RTL
================

Name: mul_add_seq

Overview:
- Sequential shift-and-add multiply-accumulate unit that computes product = multiplier * multiplicand + addend.
- Performs the inverse operation of the team's combinational divider: feeding it quotient, denominator and remainder rebuilds the numerator.
- Used in the Laboratorio3 datapath to check division results and as a standalone multiplier.
- Fixed latency with a start/busy/done handshake.

Parameters:
- WIDTH, 4, bit width of multiplier, multiplicand and addend; product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- multiplier  input  WIDTH  unsigned operand A (e.g. quotient)
- multiplicand  input  WIDTH  unsigned operand B (e.g. denominator)
- addend  input  WIDTH  unsigned value added to A*B (e.g. remainder)
- product  output  2*WIDTH  result A*B+addend
- busy  output  1  high while a computation is in progress
- done  output  1  one-cycle pulse when product becomes valid

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: while rst_n=0, state=IDLE and product=0, busy=0, done=0. All internal registers are cleared. Reset is asserted asynchronously and released synchronously to clk by the system.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If start=1 at an edge, latch A, B and addend.
  - Load the accumulator with the zero-extended addend and the bit counter with 0.
  - Go to CALC.
  - Otherwise stay in IDLE.
- CALC, executed each edge:
  - If the current LSB of the shifted A is 1, accumulator += B << counter, computed in 2*WIDTH bits with no overflow possible.
  - Shift A right by 1 and increment the counter.
  - After WIDTH iterations, go to DONE.
- DONE:
  - Copy the accumulator to product. done=1 for exactly this one cycle.
  - Return to IDLE on the next edge.
- busy=1 in CALC and DONE, 0 in IDLE.
- Latency: if start is sampled at edge N, done is high during the cycle after edge N+WIDTH+1, i.e. WIDTH+2 cycles start-to-done for WIDTH=4. Latency is fixed and independent of operand values (zero operands still take WIDTH iterations).
- product holds its last value until the next DONE; it changes only on entry to DONE or on reset.
- start while busy=1 is ignored: no restart, no queueing, and operands are not re-latched.
- Operand inputs may change after the start edge without affecting the result.
- start held high continuously: a new computation starts in the first IDLE cycle after DONE, so back-to-back operations take WIDTH+2 cycles each.
- Reset mid-operation: abort immediately, go to IDLE, outputs return to reset values, and no done pulse is produced.
- Width rule: the maximum result (2^W-1)^2+(2^W-1) = 2^(2W)-2^W fits in 2*WIDTH bits. The result is exact for all inputs.

Test Plan:
- Reset release, then start with A=2, B=6, addend=1 -> done pulses exactly 6 cycles after the start edge and product=8'h0D (13). Inverse-checks the divider case 13/6.
- A=15, B=15, addend=15 -> product=8'hF0 (240). busy is high from the cycle after start until done inclusive.
- A=0, B=9, addend=0 -> product=8'h00. done still arrives after the fixed latency of 6 cycles.
- Start with A=3, B=5, addend=0. Pulse start again with A=7, B=7 two cycles later -> product=8'h0F, exactly one done pulse, and the second request is ignored.
- Start with A=9, B=9, assert rst_n=0 mid-CALC -> product, busy and done go to 0 immediately with no done pulse. After release, start with A=1, B=1, addend=1 -> product=8'h02.
- start held high across two operations: 4*4+0 then 5*3+2 -> product=8'h10 then 8'h11, with done pulses 6 cycles apart.

Source files
------------

// File: rtl/mul_add_seq_if.sv
// Handshake and operand bundle for the sequential multiply-accumulate unit.
// The requester drives start and operands; the unit returns product, busy and done.
interface mul_add_seq_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic [WIDTH-1:0]   multiplier;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

  modport master (
    output start, multiplier, multiplicand, addend,
    input  product, busy, done
  );

  modport slave (
    input  start, multiplier, multiplicand, addend,
    output product, busy, done
  );
endinterface

// File: rtl/mul_add_seq.sv
// Shift-and-add multiply-accumulate: product = multiplier * multiplicand + addend.
// Fixed latency of WIDTH iterations plus load and result cycles, independent of operands.
module mul_add_seq #(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  mul_add_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     a_sh;
  logic [WIDTH-1:0]     b_reg;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   product_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   b_ext;

  assign b_ext = {{WIDTH{1'b0}}, b_reg};

  // NOTE: every register, including the operand latches, is cleared by reset so an
  // aborted computation leaves no stale state behind; all updates use <= so each
  // branch sees the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.multiplier;
            b_reg  <= bus.multiplicand;
            acc    <= {{WIDTH{1'b0}}, bus.addend};
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= CALC;
          end else begin
            busy_q <= 1'b0;
          end
        end

        CALC: begin
          if (a_sh[0]) begin
            acc <= acc + (b_ext << cnt);
          end
          a_sh <= a_sh >> 1;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
          end
        end

        DONE: begin
          // Outputs are registered, so the pulse is seen in the cycle after this state.
          product_q <= acc;
          done_q    <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
